// File: rtl/sub_arbiter_pkg.sv
// ============================================================
// Module : sub_arbiter_pkg -- shared widths, defaults, subtract helper
// Rev    : 1.0
// ============================================================
`default_nettype none

package sub_arbiter_pkg;

  localparam int C_OP_W    = 4;
  localparam int C_RES_W   = 5;
  localparam int C_NUM_REQ = 4;
  localparam int C_LATENCY = 3;
  localparam int C_ID_W    = 2;

  typedef logic        [C_OP_W-1:0]  operand_t;
  typedef logic signed [C_RES_W-1:0] result_t;

  // Zero-extend both operands so the 5-bit result covers -15..+15.
  function automatic result_t sub_ext(input operand_t a, input operand_t b);
    return result_t'({1'b0, a}) - result_t'({1'b0, b});
  endfunction

endpackage

`default_nettype wire

// File: rtl/sub_later.sv
// ============================================================
// Module : sub_later -- unsigned 4-bit subtract, LATENCY-stage registered
// Rev    : 1.0
// ============================================================
`default_nettype none

module sub_later
  import sub_arbiter_pkg::*;
#(
  parameter int LATENCY = C_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic        [C_OP_W-1:0]  aIn,
  input  logic        [C_OP_W-1:0]  bIn,
  output logic signed [C_RES_W-1:0] subOut
);

  result_t r_pipe [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= sub_ext(aIn, bIn);
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign subOut = r_pipe[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/sub_arbiter.sv
// ============================================================
// Module : sub_arbiter -- round-robin arbiter sharing one pipelined subtractor
// Rev    : 1.0
// ============================================================
`default_nettype none

module sub_arbiter
  import sub_arbiter_pkg::*;
#(
  parameter int NUM_REQ = C_NUM_REQ,
  parameter int LATENCY = C_LATENCY
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic        [NUM_REQ-1:0]         reqValid,
  input  logic        [C_OP_W*NUM_REQ-1:0]  reqA,
  input  logic        [C_OP_W*NUM_REQ-1:0]  reqB,
  output logic        [NUM_REQ-1:0]         reqReady,
  output logic                              respValid,
  output logic        [C_ID_W-1:0]          respId,
  output logic signed [C_RES_W-1:0]         respData,
  output logic        [$clog2(LATENCY+1)-1:0] inFlight
);

  localparam int CNT_W = $clog2(LATENCY+1);
  localparam int SUM_W = C_ID_W + 1;

  logic [C_ID_W-1:0]  r_ptr;
  logic [LATENCY-1:0] r_vld;
  logic [C_ID_W-1:0]  r_id [LATENCY];
  logic [CNT_W-1:0]   r_inflight;

  logic [NUM_REQ-1:0] w_rot;
  logic [C_ID_W-1:0]  w_off;
  logic [SUM_W-1:0]   w_sum;
  logic [C_ID_W-1:0]  w_gidx;
  logic [C_ID_W-1:0]  w_next_ptr;
  logic               w_issue;
  operand_t           w_a;
  operand_t           w_b;
  result_t            w_sub;

  // Rotate so bit 0 is the requester under the pointer; lowest set bit wins.
  assign w_rot = NUM_REQ'({reqValid, reqValid} >> r_ptr);

  always_comb begin
    w_off = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (w_rot[i]) w_off = C_ID_W'(i);
    end
  end

  assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_gidx     = (w_sum >= SUM_W'(NUM_REQ)) ? C_ID_W'(w_sum - SUM_W'(NUM_REQ))
                                                 : C_ID_W'(w_sum);
  assign w_issue    = rst_n && (|reqValid);
  assign w_next_ptr = (w_gidx == C_ID_W'(NUM_REQ-1)) ? '0 : w_gidx + C_ID_W'(1);
  assign reqReady   = w_issue ? (NUM_REQ'(1) << w_gidx) : '0;

  // Idle cycles feed 0-0 so the result pipe reads 0 wherever no issue sits.
  assign w_a = w_issue ? reqA[w_gidx*C_OP_W +: C_OP_W] : '0;
  assign w_b = w_issue ? reqB[w_gidx*C_OP_W +: C_OP_W] : '0;

  sub_later #(
    .LATENCY (LATENCY)
  ) u_sub (
    .clk    (clk),
    .rst_n  (rst_n),
    .aIn    (w_a),
    .bIn    (w_b),
    .subOut (w_sub)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_vld      <= '0;
      r_inflight <= '0;
      for (int i = 0; i < LATENCY; i++) r_id[i] <= '0;
    end else begin
      if (w_issue) r_ptr <= w_next_ptr;
      r_vld[0] <= w_issue;
      r_id[0]  <= w_issue ? w_gidx : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
      case ({w_issue, r_vld[LATENCY-1]})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign respValid = r_vld[LATENCY-1];
  assign respId    = r_id[LATENCY-1];
  assign respData  = w_sub;
  assign inFlight  = r_inflight;

endmodule

`default_nettype wire

// File: tb/tb_sub_arbiter.sv
// ============================================================
// Module : tb_sub_arbiter -- self-checking bench for sub_arbiter
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_sub_arbiter;

  localparam int N    = 4;
  localparam int LAT  = 3;
  localparam int HMAX = 4096;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      reqValid;
  logic [4*N-1:0]    reqA;
  logic [4*N-1:0]    reqB;
  logic [N-1:0]      reqReady;
  logic              respValid;
  logic [1:0]        respId;
  logic signed [4:0] respData;
  logic [1:0]        inFlight;

  int tests = 0;
  int fails = 0;

  sub_arbiter #(.NUM_REQ(N), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reqValid  (reqValid),
    .reqA      (reqA),
    .reqB      (reqB),
    .reqReady  (reqReady),
    .respValid (respValid),
    .respId    (respId),
    .respData  (respData),
    .inFlight  (inFlight)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic put(input int i, input int a, input int b);
    reqValid[i]     = 1'b1;
    reqA[i*4 +: 4]  = 4'(a);
    reqB[i*4 +: 4]  = 4'(b);
  endtask

  task automatic nextcyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: per-cycle issue history; a result is due LAT cycles
  // after its issue cycle, in-flight = issues in the last LAT cycles.
  bit hv  [HMAX];
  int hid [HMAX];
  int hd  [HMAX];
  int m    = 0;
  int mptr = 0;

  always @(negedge clk) begin : p_model
    int gi, ev, eid, ed, ef;
    logic [N-1:0] erdy;
    erdy = '0; ev = 0; eid = 0; ed = 0; ef = 0; gi = -1;
    if (!rst_n) begin
      mptr  = 0;
      hv[m] = 1'b0;
      for (int j = 1; j <= LAT; j++) if (m - j >= 0) hv[m-j] = 1'b0;
    end else begin
      for (int off = 0; off < N; off++)
        if (gi < 0 && reqValid[(mptr + off) % N]) gi = (mptr + off) % N;
      hv[m] = (gi >= 0);
      if (gi >= 0) begin
        erdy[gi] = 1'b1;
        hid[m]   = gi;
        hd[m]    = int'(reqA[gi*4 +: 4]) - int'(reqB[gi*4 +: 4]);
        mptr     = (gi + 1) % N;
      end
      if (m >= LAT && hv[m-LAT]) begin
        ev = 1; eid = hid[m-LAT]; ed = hd[m-LAT];
      end
      for (int j = 1; j <= LAT; j++) if (m - j >= 0 && hv[m-j]) ef++;
    end
    chk("model_ready",    reqReady,          erdy);
    chk("model_valid",    respValid,         ev);
    chk("model_id",       respId,            eid);
    chk("model_data",     $signed(respData), ed);
    chk("model_inflight", inFlight,          ef);
    if (m < HMAX - 1) m++;
  end

  int ua [4] = '{5, 3, 0, 15};
  int ub [4] = '{8, 3, 15, 0};
  int ur [4] = '{-3, 0, -15, 15};
  int cf [10] = '{0, 1, 2, 3, 3, 3, 3, 2, 1, 0};

  initial begin
    rst_n = 1'b0; reqValid = '0; reqA = '0; reqB = '0;
    repeat (2) nextcyc();
    reqValid = '1;
    @(negedge clk);
    chk("rst_ready", reqReady, 0);
    chk("rst_valid", respValid, 0);
    chk("rst_inflight", inFlight, 0);
    chk("rst_data", $signed(respData), 0);
    nextcyc();
    rst_n = 1'b1; reqValid = '0;

    // Single request (10,6) -> +4 from requester 0.
    put(0, 10, 6);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) chk("single_grant", reqReady, 1);
      if (c == 3) begin
        chk("single_valid", respValid, 1);
        chk("single_id", respId, 0);
        chk("single_data", $signed(respData), 4);
      end else chk("single_quiet", respValid, 0);
      nextcyc();
      reqValid = '0;
    end

    // Underflow / zero / extremes, back to back on requester 0.
    for (int c = 0; c < 7; c++) begin
      if (c < 4) put(0, ua[c], ub[c]); else reqValid = '0;
      @(negedge clk);
      if (c < 4)  chk("uf_grant", reqReady, 1);
      if (c >= 3) chk("uf_data", $signed(respData), ur[c-3]);
      nextcyc();
    end

    rst_n = 1'b0; nextcyc(); rst_n = 1'b1;

    // Contention from pointer 0: grants and responses in order 0..3.
    for (int i = 0; i < N; i++) put(i, 3*i + 2, i);
    for (int c = 0; c < 7; c++) begin
      if (c >= 4) reqValid = '0;
      @(negedge clk);
      if (c < 4) chk("cont_grant", reqReady, 1 << c);
      if (c >= 3) begin
        chk("cont_id", respId, c - 3);
        chk("cont_data", $signed(respData), 2*(c-3) + 2);
      end
      nextcyc();
    end

    // Fairness: requesters 1 and 3 alternate.
    reqValid = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("fair_grant", reqReady, (c % 2 == 0) ? 4'b0010 : 4'b1000);
      nextcyc();
    end
    reqValid = '0;
    repeat (4) nextcyc();

    // Continuous single-requester stream: in-flight ramps and drains.
    put(2, 9, 1);
    for (int c = 0; c < 10; c++) begin
      if (c >= 6) reqValid = '0;
      @(negedge clk);
      chk("cnt_inflight", inFlight, cf[c]);
      nextcyc();
    end

    // Reset while three operations are in flight.
    put(1, 7, 2);
    repeat (3) nextcyc();
    rst_n = 1'b0; reqValid = '1;
    @(negedge clk);
    chk("midrst_ready", reqReady, 0);
    repeat (2) nextcyc();
    rst_n = 1'b1; reqValid = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst_valid", respValid, 0);
      chk("midrst_inflight", inFlight, 0);
      nextcyc();
    end
    reqValid = '1;
    @(negedge clk);
    chk("midrst_ptr0", reqReady, 1);
    nextcyc();
    reqValid = '0;
    repeat (4) nextcyc();

    // Randomized traffic with occasional resets; checked by the model.
    for (int c = 0; c < 1500; c++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      reqValid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      reqA     = 16'($urandom);
      reqB     = 16'($urandom);
      nextcyc();
    end
    rst_n = 1'b1; reqValid = '0;
    repeat (6) nextcyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
